// File: rtl/pkt_sender.sv
// pkt_sender: buffers one packet from a simple load port and replays it
// as a contiguous sop/eop/val stream once downstream busy is low.
module pkt_sender #(
    parameter int AWIDTH = 3,
    parameter int DWIDTH = 8
) (
    input  logic              clk_i,
    input  logic              arstn_i,
    input  logic [DWIDTH-1:0] ld_data_i,
    input  logic              ld_val_i,
    input  logic              ld_last_i,
    output logic              ready_o,
    input  logic              busy_i,
    output logic [DWIDTH-1:0] data_o,
    output logic              sop_o,
    output logic              eop_o,
    output logic              val_o,
    output logic              done_o
);
    typedef enum logic [1:0] {LOAD, WAIT, SEND} state_t;
    state_t state;
    logic [DWIDTH-1:0] mem [2**AWIDTH];
    logic [AWIDTH-1:0] wrptr, rdptr;
    logic [AWIDTH:0]   len;

    always_ff @(posedge clk_i)
        if (state == LOAD && ld_val_i) mem[wrptr] <= ld_data_i;

    always_ff @(posedge clk_i or negedge arstn_i)
        if (!arstn_i) begin
            state   <= LOAD;
            wrptr   <= '0;
            rdptr   <= '0;
            len     <= '0;
            ready_o <= 1'b1;
            val_o   <= 1'b0;
            sop_o   <= 1'b0;
            eop_o   <= 1'b0;
            done_o  <= 1'b0;
            data_o  <= '0;
        end else begin
            done_o <= 1'b0;
            case (state)
                LOAD: if (ld_val_i) begin
                    wrptr <= wrptr + AWIDTH'(1);
                    // a full buffer forces the current word to be the last
                    if (ld_last_i || &wrptr) begin
                        len     <= {1'b0, wrptr} + (AWIDTH+1)'(1);
                        state   <= WAIT;
                        ready_o <= 1'b0;
                    end
                end
                WAIT: if (!busy_i) begin
                    state  <= SEND;
                    rdptr  <= AWIDTH'(1);
                    val_o  <= 1'b1;
                    sop_o  <= 1'b1;
                    data_o <= mem[AWIDTH'(0)];
                    eop_o  <= len == (AWIDTH+1)'(1);
                end
                SEND: if (eop_o) begin
                    val_o   <= 1'b0;
                    sop_o   <= 1'b0;
                    eop_o   <= 1'b0;
                    done_o  <= 1'b1;
                    wrptr   <= '0;
                    state   <= LOAD;
                    ready_o <= 1'b1;
                end else begin
                    data_o <= mem[rdptr];
                    sop_o  <= 1'b0;
                    eop_o  <= {1'b0, rdptr} == len - (AWIDTH+1)'(1);
                    rdptr  <= rdptr + AWIDTH'(1);
                end
                default: state <= LOAD;
            endcase
        end
endmodule

// File: tb/tb_pkt_sender.sv
// tb_pkt_sender: randomized packets checked against a queue-based model
// of the expected stream, framing and timing.
module tb_pkt_sender;
    logic       clk_i = 1'b0;
    logic       arstn_i = 1'b0;
    logic [7:0] ld_data_i = '0;
    logic       ld_val_i = 1'b0;
    logic       ld_last_i = 1'b0;
    logic       ready_o;
    logic       busy_i = 1'b0;
    logic [7:0] data_o;
    logic       sop_o, eop_o, val_o, done_o;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    logic [7:0] gd[$];
    logic       gs[$], ge[$];
    int         gc[$], done_q[$];
    logic [7:0] fx[$];

    pkt_sender #(.AWIDTH(3), .DWIDTH(8)) dut (
        .clk_i(clk_i), .arstn_i(arstn_i), .ld_data_i(ld_data_i),
        .ld_val_i(ld_val_i), .ld_last_i(ld_last_i), .ready_o(ready_o),
        .busy_i(busy_i), .data_o(data_o), .sop_o(sop_o), .eop_o(eop_o),
        .val_o(val_o), .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // observed stream, sampled on the falling edge
    always @(negedge clk_i) if (arstn_i) begin
        if (val_o) begin
            gd.push_back(data_o);
            gs.push_back(sop_o);
            ge.push_back(eop_o);
            gc.push_back(cyc);
        end else begin
            check("idle_sop", sop_o, 1'b0);
            check("idle_eop", eop_o, 1'b0);
        end
        if (done_o) done_q.push_back(cyc);
    end

    task automatic step();
        @(negedge clk_i);
        #1;
    endtask

    task automatic clear_obs();
        gd.delete(); gs.delete(); ge.delete(); gc.delete(); done_q.delete();
    endtask

    task automatic run_pkt(input int n, input bit use_last, input int busy_cyc, input bit busy_mid);
        logic [7:0] w[$];
        int eff, last_ld, rel, first_exp;
        eff = use_last ? n : (n > 8 ? 8 : n);
        rel = -1;
        last_ld = 0;
        clear_obs();
        busy_i = busy_cyc > 0;
        check("rdy_idle", ready_o, 1'b1);
        for (int i = 0; i < n; i++) begin
            w.push_back(fx.size() > i ? fx[i] : 8'($urandom));
            ld_data_i = w[i];
            ld_val_i = 1'b1;
            ld_last_i = use_last && i == n - 1;
            if (i == eff - 1) last_ld = cyc;
            step();
            check("rdy_ld", ready_o, i < eff - 1);
        end
        ld_val_i = 1'b0;
        ld_last_i = 1'b0;
        if (busy_cyc > 0) begin
            repeat (busy_cyc) begin
                check("val_busy", val_o, 1'b0);
                step();
            end
            busy_i = 1'b0;
            rel = cyc;
        end
        first_exp = (last_ld + 2 > rel + 1) ? last_ld + 2 : rel + 1;
        for (int k = 0; k < 40 && done_q.size() == 0; k++) begin
            if (busy_mid && gd.size() == 2) busy_i = 1'b1;
            step();
        end
        check("done_seen", done_q.size(), 1);
        check("n_words", gd.size(), eff);
        for (int i = 0; i < gd.size() && i < eff; i++) begin
            check("data", gd[i], w[i]);
            check("sop", gs[i], i == 0);
            check("eop", ge[i], i == eff - 1);
            check("word_cyc", gc[i], first_exp + i);
        end
        if (done_q.size() > 0) check("done_cyc", done_q[0], first_exp + eff);
        check("rdy_after", ready_o, 1'b1);
        step();
        check("done_pulse", done_o, 1'b0);
        busy_i = 1'b0;
    endtask

    initial begin
        step();
        check("rst_ready", ready_o, 1'b1);
        check("rst_val", val_o, 1'b0);
        check("rst_sop", sop_o, 1'b0);
        check("rst_eop", eop_o, 1'b0);
        check("rst_done", done_o, 1'b0);
        check("rst_data", data_o, 8'h00);
        arstn_i = 1'b1;
        step();

        fx = '{8'd5, 8'd3, 8'd7, 8'd1};
        run_pkt(4, 1'b1, 0, 1'b0);
        fx = '{8'hA5};
        run_pkt(1, 1'b1, 0, 1'b0);
        fx = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'hFF};
        run_pkt(9, 1'b0, 0, 1'b0);
        fx.delete();
        run_pkt(6, 1'b1, 10, 1'b0);
        run_pkt(5, 1'b1, 0, 1'b1);

        // reset on the third word of a send aborts at once
        clear_obs();
        for (int i = 0; i < 5; i++) begin
            ld_data_i = 8'($urandom);
            ld_val_i = 1'b1;
            ld_last_i = i == 4;
            step();
        end
        ld_val_i = 1'b0;
        ld_last_i = 1'b0;
        for (int k = 0; k < 20 && gd.size() < 3; k++) step();
        check("rst_reach3", gd.size(), 3);
        arstn_i = 1'b0;
        #1;
        check("abort_val", val_o, 1'b0);
        check("abort_sop", sop_o, 1'b0);
        check("abort_eop", eop_o, 1'b0);
        check("abort_ready", ready_o, 1'b1);
        step();
        arstn_i = 1'b1;
        step();
        run_pkt(2, 1'b1, 0, 1'b0);

        for (int t = 0; t < 20; t++)
            run_pkt($urandom_range(1, 8), 1'b1, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        run_pkt(10, 1'b0, 2, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/pkt_sender.md
Name: pkt_sender

Overview:
- Transmit-side counterpart of the packet sorter's input interface.
- Buffers one packet, loaded word by word from a simple load port.
- Replays the packet as a contiguous sop/eop/val/data stream, and starts only while the downstream busy signal is low.
- Sits in front of the sorter as stimulus/source; its outputs connect directly to the sorter's data_i/sop_i/eop_i/val_i, and its busy_i connects to the sorter's busy_o.

Parameters:
- AWIDTH, 3: buffer address width. Maximum packet length is 2**AWIDTH words.
- DWIDTH, 8: data word width.

Ports:
- clk_i  in  1  clock; all flops on rising edge.
- arstn_i  in  1  asynchronous active-low reset.
- ld_data_i  in  DWIDTH  word to append to the buffer.
- ld_val_i  in  1  ld_data_i valid; accepted only while ready_o=1.
- ld_last_i  in  1  qualifies ld_val_i; marks the final word of the packet.
- ready_o  out  1  buffer is accepting load words (state LOAD).
- busy_i  in  1  downstream busy; transmission may not start while it is 1.
- data_o  out  DWIDTH  transmitted word.
- sop_o  out  1  first word of packet.
- eop_o  out  1  last word of packet.
- val_o  out  1  valid for data_o/sop_o/eop_o.
- done_o  out  1  one-cycle pulse after the eop word has been sent.

Behaviour:
- Reset (arstn_i=0, asynchronous):
  - state=LOAD; write pointer=0; length=0; read pointer=0.
  - ready_o=1; val_o=0; sop_o=0; eop_o=0; done_o=0; data_o=0.
  - Buffer contents are not reset.
  - Reset asserted mid-load or mid-send aborts immediately; outputs drop in the same cycle.
- Storage: 2**AWIDTH x DWIDTH register array, combinational read. Length register is AWIDTH+1 bits wide (range 1..2**AWIDTH).
- All outputs are registered.
- State LOAD (ready_o=1):
  - Each edge with ld_val_i=1 writes ld_data_i to mem[wrptr] and increments wrptr.
  - If ld_last_i=1, or wrptr==2**AWIDTH-1 (buffer full, so last is forced): length<=wrptr+1, state->WAIT, ready_o<=0.
  - ld_last_i without ld_val_i is ignored.
- State WAIT:
  - ld_val_i is ignored and nothing is written.
  - At the first edge with busy_i=0: state->SEND, rdptr<=1, val_o<=1, sop_o<=1, data_o<=mem[0], eop_o<=(length==1).
  - Latency: the first word is on the outputs in the cycle after busy_i is sampled low.
- State SEND:
  - Each edge emits data_o<=mem[rdptr], val_o=1, sop_o=0, eop_o<=(rdptr==length-1), and increments rdptr.
  - The packet occupies exactly length consecutive cycles with no gaps; busy_i is not re-checked during SEND.
  - On the edge after the eop word: val_o<=0, eop_o<=0, done_o<=1 for one cycle, wrptr<=0, state->LOAD, ready_o<=1.
- Single-word packet: sop_o=eop_o=val_o=1 in the same cycle.
- sop_o and eop_o are 0 whenever val_o=0. data_o holds its last value when val_o=0.
- busy_i toggling while in LOAD has no effect.
- The load port is stalled during WAIT and SEND. The source must hold ld_* until ready_o=1; words presented while ready_o=0 are dropped.
- Minimum packet-to-packet spacing is one idle cycle (the done_o cycle), plus the reload time.

Test Plan:
- Reset, then load 5,3,7,1 with last on 1, busy_i=0 → ready_o falls after the 4th load. Next edge: sop on 5, then 3, 7, eop on 1 with val_o=1 for 4 cycles, then done_o pulse and ready_o=1.
- Load a single word 0xA5 with ld_last_i=1 → one cycle with val_o=sop_o=eop_o=1 and data_o=0xA5.
- Load 8 words 0..7 with no ld_last_i → forced last at word 7. A 9th ld_val_i (value 0xFF) is dropped. Output is 0..7 with eop on 7.
- Packet loaded while busy_i=1 for 10 cycles → val_o stays 0 throughout. First sop appears the cycle after busy_i drops.
- busy_i raised during the 2nd word of SEND → the remaining words still go out back to back.
- arstn_i pulsed low on the 3rd word of SEND → val_o/sop_o/eop_o go 0 immediately, ready_o=1. A fresh 2-word packet then sends correctly.
